// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX arbiter.
// ETH_TX_ARB_WATCHDOG_EN adds the ABORT/DRAIN states used by the stall watchdog.
package eth_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  localparam logic [AXIS_KEEP_W-1:0] ABORT_TKEEP = 8'h01;

`ifdef ETH_TX_ARB_WATCHDOG_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT0,
    ST_GRANT1,
    ST_ABORT,
    ST_DRAIN
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT0,
    ST_GRANT1
  } arb_state_e;
`endif

endpackage

// File: rtl/eth_tx_wdog.sv
// Stall watchdog for the TX arbiter: counts owner-idle cycles while the MAC is ready,
// flags expiry after WDOG_CYCLES such cycles, and keeps a saturating abort count.
module eth_tx_wdog #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic        clk156,
  input  logic        eth_rst,
  input  logic        active,
  input  logic        src_valid,
  input  logic        dst_ready,
  output logic        expire,
  output logic [15:0] abort_cnt
);

  localparam int              CNT_W    = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] stall_cnt;
  logic             stall;

  // MAC backpressure holds the count rather than advancing it
  assign stall  = active && !src_valid && dst_ready;
  assign expire = stall && (stall_cnt == CNT_LAST);

  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) begin
      stall_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      if (!active || src_valid)
        stall_cnt <= '0;
      else if (stall)
        stall_cnt <= stall_cnt + 1'b1;

      if (expire && (abort_cnt != 16'hFFFF))
        abort_cnt <= abort_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular two-requester AXI-stream arbiter feeding a 10G MAC TX port.
// Build option ETH_TX_ARB_WATCHDOG_EN adds the stall watchdog (ABORT/DRAIN, abort_cnt).
//
// state  | meaning
// IDLE   | no owner; choose next requester, all outputs quiet
// GRANT0 | s0 owns m_axis until its accepted tlast
// GRANT1 | s1 owns m_axis until its accepted tlast
// ABORT  | owner stalled too long; present one error tlast beat to the MAC
// DRAIN  | swallow the stalled owner's remaining beats through its tlast
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                   clk156,
  input  logic                   eth_rst,

  input  logic                   s0_axis_tx_tvalid,
  output logic                   s0_axis_tx_tready,
  input  logic [AXIS_DATA_W-1:0] s0_axis_tx_tdata,
  input  logic [AXIS_KEEP_W-1:0] s0_axis_tx_tkeep,
  input  logic                   s0_axis_tx_tlast,
  input  logic                   s0_axis_tx_tuser,

  input  logic                   s1_axis_tx_tvalid,
  output logic                   s1_axis_tx_tready,
  input  logic [AXIS_DATA_W-1:0] s1_axis_tx_tdata,
  input  logic [AXIS_KEEP_W-1:0] s1_axis_tx_tkeep,
  input  logic                   s1_axis_tx_tlast,
  input  logic                   s1_axis_tx_tuser,

  output logic                   m_axis_tx_tvalid,
  input  logic                   m_axis_tx_tready,
  output logic [AXIS_DATA_W-1:0] m_axis_tx_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tx_tkeep,
  output logic                   m_axis_tx_tlast,
  output logic                   m_axis_tx_tuser,

  output logic [1:0]             grant,
  output logic [15:0]            abort_cnt
);

  arb_state_e state, state_nxt;
  logic       owner;       // 0 = s0, 1 = s1; valid while not IDLE
  logic       last_grant;

  if (WDOG_CYCLES < 2) begin : g_bad_wdog_cycles
    $error("eth_tx_arbiter: WDOG_CYCLES must be at least 2");
  end

`ifdef ETH_TX_ARB_WATCHDOG_EN
  logic owner_valid, owner_last, wdog_active, wdog_expire;

  assign owner_valid = owner ? s1_axis_tx_tvalid : s0_axis_tx_tvalid;
  assign owner_last  = owner ? s1_axis_tx_tlast  : s0_axis_tx_tlast;
  assign wdog_active = (state == ST_GRANT0) || (state == ST_GRANT1);

  eth_tx_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk156   (clk156),
    .eth_rst  (eth_rst),
    .active   (wdog_active),
    .src_valid(owner_valid),
    .dst_ready(m_axis_tx_tready),
    .expire   (wdog_expire),
    .abort_cnt(abort_cnt)
  );
`else
  assign abort_cnt = '0;
`endif

  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) begin
      state      <= ST_IDLE;
      owner      <= 1'b1;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && (state_nxt != ST_IDLE))
        owner <= (state_nxt == ST_GRANT1);
      if ((state != ST_IDLE) && (state_nxt == ST_IDLE))
        last_grant <= owner;
    end
  end

  always_comb begin
    state_nxt         = state;
    grant             = 2'b00;
    s0_axis_tx_tready = 1'b0;
    s1_axis_tx_tready = 1'b0;
    m_axis_tx_tvalid  = 1'b0;
    m_axis_tx_tdata   = '0;
    m_axis_tx_tkeep   = '0;
    m_axis_tx_tlast   = 1'b0;
    m_axis_tx_tuser   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (s0_axis_tx_tvalid && s1_axis_tx_tvalid)
          state_nxt = last_grant ? ST_GRANT0 : ST_GRANT1;
        else if (s0_axis_tx_tvalid)
          state_nxt = ST_GRANT0;
        else if (s1_axis_tx_tvalid)
          state_nxt = ST_GRANT1;
      end

      ST_GRANT0: begin
        grant             = 2'b01;
        m_axis_tx_tvalid  = s0_axis_tx_tvalid;
        m_axis_tx_tdata   = s0_axis_tx_tdata;
        m_axis_tx_tkeep   = s0_axis_tx_tkeep;
        m_axis_tx_tlast   = s0_axis_tx_tlast;
        m_axis_tx_tuser   = s0_axis_tx_tuser;
        s0_axis_tx_tready = m_axis_tx_tready;
        if (s0_axis_tx_tvalid && m_axis_tx_tready && s0_axis_tx_tlast)
          state_nxt = ST_IDLE;
`ifdef ETH_TX_ARB_WATCHDOG_EN
        else if (wdog_expire)
          state_nxt = ST_ABORT;
`endif
      end

      ST_GRANT1: begin
        grant             = 2'b10;
        m_axis_tx_tvalid  = s1_axis_tx_tvalid;
        m_axis_tx_tdata   = s1_axis_tx_tdata;
        m_axis_tx_tkeep   = s1_axis_tx_tkeep;
        m_axis_tx_tlast   = s1_axis_tx_tlast;
        m_axis_tx_tuser   = s1_axis_tx_tuser;
        s1_axis_tx_tready = m_axis_tx_tready;
        if (s1_axis_tx_tvalid && m_axis_tx_tready && s1_axis_tx_tlast)
          state_nxt = ST_IDLE;
`ifdef ETH_TX_ARB_WATCHDOG_EN
        else if (wdog_expire)
          state_nxt = ST_ABORT;
`endif
      end

`ifdef ETH_TX_ARB_WATCHDOG_EN
      // Error-marked terminating beat so the MAC discards the partial frame
      ST_ABORT: begin
        grant            = owner ? 2'b10 : 2'b01;
        m_axis_tx_tvalid = 1'b1;
        m_axis_tx_tkeep  = ABORT_TKEEP;
        m_axis_tx_tlast  = 1'b1;
        m_axis_tx_tuser  = 1'b1;
        if (m_axis_tx_tready)
          state_nxt = ST_DRAIN;
      end

      ST_DRAIN: begin
        grant             = owner ? 2'b10 : 2'b01;
        s0_axis_tx_tready = !owner;
        s1_axis_tx_tready = owner;
        if (owner_valid && owner_last)
          state_nxt = ST_IDLE;
      end
`endif

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed self-checking bench for eth_tx_arbiter (WDOG_CYCLES = 16).
// Exercises the watchdog path when ETH_TX_ARB_WATCHDOG_EN is defined, the held-grant path otherwise.
module tb_eth_tx_arbiter;

  logic        clk156 = 1'b0;
  logic        eth_rst = 1'b1;
  logic        s0_tvalid, s0_tready, s0_tlast, s0_tuser;
  logic [63:0] s0_tdata;
  logic [7:0]  s0_tkeep;
  logic        s1_tvalid, s1_tready, s1_tlast, s1_tuser;
  logic [63:0] s1_tdata;
  logic [7:0]  s1_tkeep;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic [1:0]  grant;
  logic [15:0] abort_cnt;

  int checks = 0;
  int errors = 0;

  always #3 clk156 = ~clk156;

  eth_tx_arbiter #(.WDOG_CYCLES(16)) dut (
    .clk156           (clk156),
    .eth_rst          (eth_rst),
    .s0_axis_tx_tvalid(s0_tvalid),
    .s0_axis_tx_tready(s0_tready),
    .s0_axis_tx_tdata (s0_tdata),
    .s0_axis_tx_tkeep (s0_tkeep),
    .s0_axis_tx_tlast (s0_tlast),
    .s0_axis_tx_tuser (s0_tuser),
    .s1_axis_tx_tvalid(s1_tvalid),
    .s1_axis_tx_tready(s1_tready),
    .s1_axis_tx_tdata (s1_tdata),
    .s1_axis_tx_tkeep (s1_tkeep),
    .s1_axis_tx_tlast (s1_tlast),
    .s1_axis_tx_tuser (s1_tuser),
    .m_axis_tx_tvalid (m_tvalid),
    .m_axis_tx_tready (m_tready),
    .m_axis_tx_tdata  (m_tdata),
    .m_axis_tx_tkeep  (m_tkeep),
    .m_axis_tx_tlast  (m_tlast),
    .m_axis_tx_tuser  (m_tuser),
    .grant            (grant),
    .abort_cnt        (abort_cnt)
  );

  task automatic step();
    @(posedge clk156);
    #1;
  endtask

  task automatic clear_inputs();
    s0_tvalid = 1'b0; s0_tdata = '0; s0_tkeep = 8'hFF; s0_tlast = 1'b0; s0_tuser = 1'b0;
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = 8'hFF; s1_tlast = 1'b0; s1_tuser = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    m_tready = 1'b1;
    eth_rst = 1'b1;
    step();
    step();
    eth_rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    m_tready = 1'b1;
    s0_tvalid = 1'b1;
    eth_rst = 1'b1;
    step();
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
    checks++; if ({s0_tready, s1_tready} !== 2'b00) begin errors++; $display("FAIL reset_treadys: got %b expected 00", {s0_tready, s1_tready}); end
    checks++; if (abort_cnt !== 16'd0) begin errors++; $display("FAIL reset_abort_cnt: got %0d expected 0", abort_cnt); end
    checks++; if (m_tdata !== 64'd0) begin errors++; $display("FAIL reset_m_tdata: got %h expected 0", m_tdata); end
    eth_rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_packet();
    logic [63:0] exp_d [3] = '{64'hA0, 64'hA1, 64'hA2};
    logic [7:0]  exp_k [3] = '{8'hFF, 8'hFF, 8'h0F};
    do_reset();
    s0_tvalid = 1'b1; s0_tdata = 64'hA0; s0_tlast = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || m_tvalid !== 1'b0) begin errors++; $display("FAIL single_idle_cycle: got grant %b tvalid %b expected 00 0", grant, m_tvalid); end
    for (int b = 0; b < 3; b++) begin
      step();
      s0_tdata = exp_d[b]; s0_tkeep = exp_k[b]; s0_tlast = (b == 2); s0_tuser = 1'b0;
      #1;
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant beat %0d: got %b expected 01", b, grant); end
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== exp_d[b] || m_tkeep !== exp_k[b]) begin errors++; $display("FAIL single_beat %0d: got v%b d%h k%h expected v1 d%h k%h", b, m_tvalid, m_tdata, m_tkeep, exp_d[b], exp_k[b]); end
      checks++; if (m_tlast !== (b == 2)) begin errors++; $display("FAIL single_tlast beat %0d: got %b", b, m_tlast); end
      checks++; if (s0_tready !== 1'b1 || s1_tready !== 1'b0) begin errors++; $display("FAIL single_treadys beat %0d: got %b%b expected 10", b, s0_tready, s1_tready); end
    end
    step();
    clear_inputs();
    #1;
    checks++; if (grant !== 2'b00 || m_tvalid !== 1'b0) begin errors++; $display("FAIL single_back_to_idle: got grant %b tvalid %b expected 00 0", grant, m_tvalid); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g [12] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                                2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    logic [63:0] exp_d [12] = '{64'h000, 64'h000, 64'h001, 64'h000, 64'h100, 64'h101,
                                64'h000, 64'h010, 64'h011, 64'h000, 64'h110, 64'h111};
    int b0 = 0, b1 = 0, pk0 = 0, pk1 = 0;
    logic acc0, acc1;
    clear_inputs();
    m_tready = 1'b1;
    s0_tvalid = 1'b1;
    s1_tvalid = 1'b1;
    eth_rst = 1'b1;
    step();
    eth_rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      s0_tdata = 64'(16 * pk0 + b0);       s0_tlast = (b0 == 1);
      s1_tdata = 64'(256 + 16 * pk1 + b1); s1_tlast = (b1 == 1);
      #1;
      checks++; if (grant !== exp_g[c]) begin errors++; $display("FAIL rr_grant cycle %0d: got %b expected %b", c, grant, exp_g[c]); end
      checks++; if (m_tdata !== exp_d[c] || m_tvalid !== (exp_g[c] != 2'b00)) begin errors++; $display("FAIL rr_data cycle %0d: got v%b d%h expected d%h", c, m_tvalid, m_tdata, exp_d[c]); end
      acc0 = s0_tvalid && s0_tready;
      acc1 = s1_tvalid && s1_tready;
      step();
      if (acc0) begin if (b0 == 1) begin b0 = 0; pk0++; end else b0++; end
      if (acc1) begin if (b1 == 1) begin b1 = 0; pk1++; end else b1++; end
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    s1_tvalid = 1'b1; s1_tdata = 64'hB0; s1_tlast = 1'b0;
    step();
    #1;
    checks++; if (grant !== 2'b10 || m_tdata !== 64'hB0) begin errors++; $display("FAIL bp_first_beat: got grant %b d%h expected 10 b0", grant, m_tdata); end
    step();
    s1_tdata = 64'hB1; m_tready = 1'b0;
    s0_tvalid = 1'b1; s0_tdata = 64'hC0; s0_tlast = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      checks++; if (grant !== 2'b10 || m_tvalid !== 1'b1 || m_tdata !== 64'hB1) begin errors++; $display("FAIL bp_hold cycle %0d: got grant %b v%b d%h expected 10 1 b1", i, grant, m_tvalid, m_tdata); end
      checks++; if (s0_tready !== 1'b0 || s1_tready !== 1'b0) begin errors++; $display("FAIL bp_treadys cycle %0d: got %b%b expected 00", i, s0_tready, s1_tready); end
      step();
    end
    m_tready = 1'b1;
    #1;
    checks++; if (m_tdata !== 64'hB1 || s1_tready !== 1'b1) begin errors++; $display("FAIL bp_release: got d%h rdy %b expected b1 1", m_tdata, s1_tready); end
    step();
    s1_tvalid = 1'b0; m_tready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      checks++; if (grant !== 2'b10 || m_tvalid !== 1'b0 || abort_cnt !== 16'd0) begin errors++; $display("FAIL bp_idle_stall cycle %0d: got grant %b v%b aborts %0d expected 10 0 0", i, grant, m_tvalid, abort_cnt); end
      step();
    end
    s1_tvalid = 1'b1; s1_tdata = 64'hB2; s1_tlast = 1'b1; m_tready = 1'b1;
    #1;
    checks++; if (m_tdata !== 64'hB2 || m_tlast !== 1'b1 || m_tuser !== 1'b0) begin errors++; $display("FAIL bp_last: got d%h l%b u%b expected b2 1 0", m_tdata, m_tlast, m_tuser); end
    step();
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || s0_tready !== 1'b0) begin errors++; $display("FAIL bp_idle_gap: got grant %b rdy0 %b expected 00 0", grant, s0_tready); end
    step();
    #1;
    checks++; if (grant !== 2'b01 || m_tdata !== 64'hC0) begin errors++; $display("FAIL bp_s0_next: got grant %b d%h expected 01 c0", grant, m_tdata); end
    step();
    clear_inputs();
    #1;
    checks++; if (grant !== 2'b00 || abort_cnt !== 16'd0) begin errors++; $display("FAIL bp_end: got grant %b aborts %0d expected 00 0", grant, abort_cnt); end
  endtask

  task automatic test_watchdog();
    do_reset();
    s0_tvalid = 1'b1; s0_tdata = 64'hD0; s0_tlast = 1'b0;
    step();
    #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL wd_grant: got %b expected 01", grant); end
    step();
    s0_tdata = 64'hD1;
    #1;
    checks++; if (m_tdata !== 64'hD1) begin errors++; $display("FAIL wd_beat2: got %h expected d1", m_tdata); end
    step();
    s0_tvalid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (grant !== 2'b01 || m_tvalid !== 1'b0 || abort_cnt !== 16'd0) begin errors++; $display("FAIL wd_stall cycle %0d: got grant %b v%b aborts %0d expected 01 0 0", i, grant, m_tvalid, abort_cnt); end
      step();
    end
`ifdef ETH_TX_ARB_WATCHDOG_EN
    m_tready = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b1 || m_tlast !== 1'b1 || m_tuser !== 1'b1) begin errors++; $display("FAIL wd_abort_ctrl: got v%b l%b u%b expected 1 1 1", m_tvalid, m_tlast, m_tuser); end
    checks++; if (m_tkeep !== 8'h01 || m_tdata !== 64'd0) begin errors++; $display("FAIL wd_abort_data: got k%h d%h expected 01 0", m_tkeep, m_tdata); end
    checks++; if (s0_tready !== 1'b0 || grant !== 2'b01 || abort_cnt !== 16'd1) begin errors++; $display("FAIL wd_abort_state: got rdy %b grant %b aborts %0d expected 0 01 1", s0_tready, grant, abort_cnt); end
    step();
    m_tready = 1'b1;
    #1;
    checks++; if (m_tvalid !== 1'b1 || m_tuser !== 1'b1) begin errors++; $display("FAIL wd_abort_held: got v%b u%b expected 1 1", m_tvalid, m_tuser); end
    step();
    s0_tvalid = 1'b1; s0_tdata = 64'hD2; s0_tlast = 1'b0;
    #1;
    checks++; if (s0_tready !== 1'b1 || m_tvalid !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL wd_drain: got rdy %b v%b grant %b expected 1 0 01", s0_tready, m_tvalid, grant); end
    step();
    s0_tdata = 64'hD3; s0_tlast = 1'b1;
    #1;
    checks++; if (s0_tready !== 1'b1 || m_tvalid !== 1'b0) begin errors++; $display("FAIL wd_drain_last: got rdy %b v%b expected 1 0", s0_tready, m_tvalid); end
    step();
    clear_inputs();
    #1;
    checks++; if (grant !== 2'b00 || abort_cnt !== 16'd1) begin errors++; $display("FAIL wd_end: got grant %b aborts %0d expected 00 1", grant, abort_cnt); end
`else
    for (int i = 0; i < 40; i++) begin
      #1;
      checks++; if (grant !== 2'b01 || m_tvalid !== 1'b0 || m_tuser !== 1'b0 || abort_cnt !== 16'd0) begin errors++; $display("FAIL wd_off_hold cycle %0d: got grant %b v%b u%b aborts %0d", i, grant, m_tvalid, m_tuser, abort_cnt); end
      step();
    end
    s0_tvalid = 1'b1; s0_tdata = 64'hD2; s0_tlast = 1'b1;
    #1;
    checks++; if (m_tdata !== 64'hD2 || m_tuser !== 1'b0 || s0_tready !== 1'b1) begin errors++; $display("FAIL wd_off_last: got d%h u%b rdy %b expected d2 0 1", m_tdata, m_tuser, s0_tready); end
    step();
    clear_inputs();
    #1;
    checks++; if (grant !== 2'b00 || abort_cnt !== 16'd0) begin errors++; $display("FAIL wd_off_end: got grant %b aborts %0d expected 00 0", grant, abort_cnt); end
`endif
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    s1_tvalid = 1'b1; s1_tdata = 64'hE0; s1_tlast = 1'b0;
    step();
    step();
    s1_tdata = 64'hE1;
    #1;
    checks++; if (m_tvalid !== 1'b1 || grant !== 2'b10) begin errors++; $display("FAIL rst_mid_pre: got v%b grant %b expected 1 10", m_tvalid, grant); end
    eth_rst = 1'b1;
    #1;
    checks++; if (m_tvalid !== 1'b0 || grant !== 2'b00 || m_tlast !== 1'b0 || s1_tready !== 1'b0) begin errors++; $display("FAIL rst_mid_async: got v%b grant %b l%b rdy %b expected 0 00 0 0", m_tvalid, grant, m_tlast, s1_tready); end
    step();
    eth_rst = 1'b0;
    s0_tvalid = 1'b1; s0_tdata = 64'hF0; s0_tlast = 1'b1;
    s1_tvalid = 1'b1; s1_tdata = 64'hE0; s1_tlast = 1'b1;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_mid_idle: got %b expected 00", grant); end
    step();
    #1;
    checks++; if (grant !== 2'b01 || m_tdata !== 64'hF0) begin errors++; $display("FAIL rst_mid_tie: got grant %b d%h expected 01 f0", grant, m_tdata); end
    step();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    m_tready = 1'b1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameter WDOG_CYCLES, default 1024, meaning stall cycles before a granted packet is aborted (used only with ETH_TX_ARB_WATCHDOG_EN).
REQ-002 SHALL have port clk156  input  1  156.25 MHz MAC core clock; sole clock.
REQ-003 SHALL have port eth_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports s0_axis_tx_tvalid/tready/tdata/tkeep/tlast/tuser  in/out/in/in/in/in  1/1/64/8/1/1  requester 0 AXI-stream TX.
REQ-005 SHALL have ports s1_axis_tx_tvalid/tready/tdata/tkeep/tlast/tuser  in/out/in/in/in/in  1/1/64/8/1/1  requester 1 AXI-stream TX.
REQ-006 SHALL have ports m_axis_tx_tvalid/tready/tdata/tkeep/tlast/tuser  out/in/out/out/out/out  1/1/64/8/1/1  to 10G MAC TX.
REQ-007 SHALL have port grant  output  2  one-hot current owner (01 = s0, 10 = s1, 00 = none).
REQ-008 SHALL have port abort_cnt  output  16  watchdog aborts since reset, saturating.

Function
REQ-009 SHALL arbitrate at packet granularity; a grant SHALL be held from first beat to the accepted tlast beat (tvalid & tready & tlast).
REQ-010 SHALL implement states IDLE, GRANT0, GRANT1, plus ABORT and DRAIN when watchdog compiled in.
REQ-011 IDLE: only s0 valid -> GRANT0; only s1 valid -> GRANT1; both valid -> port other than last_grant; neither -> stay.
REQ-012 Grant decision SHALL be registered: first beat appears on m_axis one cycle after tvalid seen in IDLE.
REQ-013 GRANTn: m_axis_* = sn_axis_* combinationally; sn_tready = m_axis_tx_tready; the other port's tready = 0.
REQ-014 IDLE: m_axis_tx_tvalid = 0, all s*_tready = 0, m data/keep/last/user = 0.
REQ-015 Accepted tlast beat SHALL return state to IDLE next cycle and update last_grant; one idle cycle between back-to-back packets is required.
REQ-016 grant SHALL equal 01 in GRANT0, 10 in GRANT1, 00 otherwise (ABORT/DRAIN keep owner's bit).
REQ-017 Watchdog counter SHALL count cycles in GRANTn with sn_tvalid = 0, clear on any sn_tvalid = 1 cycle, clear on state entry.
REQ-018 Counter reaching WDOG_CYCLES-1 SHALL enter ABORT: m tvalid=1, tlast=1, tuser=1, tkeep=8'h01, tdata=0, source tready=0, held until m tready.
REQ-019 ABORT accepted -> DRAIN: sn_tready=1, m tvalid=0, discard beats through sn's accepted tlast, then IDLE; if sn tlast already accepted... not possible (abort only mid-packet) -> DRAIN exits on first tlast.
REQ-020 abort_cnt SHALL increment on ABORT entry, saturate at 16'hFFFF; reads 0 when watchdog compiled out.
REQ-021 Stall with m_axis_tx_tready = 0 SHALL NOT advance the watchdog.

Reset
REQ-022 eth_rst high SHALL force IDLE, last_grant = s1 (so s0 wins first tie), watchdog counter 0, abort_cnt 0, all outputs 0 immediately.
REQ-023 Reset asserted mid-packet SHALL truncate without driving tlast; recovery requires MAC reset (shared eth_rst).

Configuration
REQ-024 Macro ETH_TX_ARB_WATCHDOG_EN defined: REQ-017..REQ-021 active, ABORT/DRAIN states present.
REQ-025 Macro undefined: no counter, no ABORT/DRAIN, grant held indefinitely on stall, abort_cnt tied 0.

Structure
REQ-026 Shared package eth_pkg SHALL hold the state enum, AXIS width constants (64/8) and abort-beat tkeep constant.
REQ-027 One sub-module eth_tx_wdog (stall counter + saturating abort counter) SHALL be used, instantiated only under the macro.

Verification
REQ-028 s0 alone sends 3-beat packet, tready=1 -> grant=01 one cycle after tvalid, 3 beats on m, IDLE after tlast.
REQ-029 s0 and s1 both valid from reset, 2-beat packets each, repeated -> order s0,s1,s0,s1; one idle cycle between packets.
REQ-030 s1 granted mid-packet, m tready low 50 cycles -> no beats lost, s0 tready stays 0, no abort.
REQ-031 Watchdog on, WDOG_CYCLES=16, s0 stalls after beat 2 -> 16 stall cycles then abort beat tuser=1 tkeep=01, drain to s0 tlast, abort_cnt=1.
REQ-032 eth_rst pulsed during beat 2 of s1 packet -> m tvalid=0 same cycle, grant=00, next tie goes to s0.
REQ-033 Watchdog off, same stall as REQ-031 -> grant held, no abort beat, abort_cnt=0.
